// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS run controller: state encoding and default issue rate.
package mips_ctrl_pkg;

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_BRK  = 2'b10;

  // 2 instructions per second from the 50 MHz board clock
  localparam int unsigned DEFAULT_RATE_DIV = 25_000_000;

  typedef enum logic [1:0] {
    S_HALT = ST_HALT,
    S_RUN  = ST_RUN,
    S_BRK  = ST_BRK
  } run_state_e;

  function automatic int unsigned div_width(input int unsigned rate);
    return (rate > 32'd1) ? 32'($clog2(rate)) : 32'd1;
  endfunction

endpackage

// File: rtl/mips_tick_gen.sv
// Free-running rate divider with synchronous clear; strobes tc_c on the last count of each period.
module mips_tick_gen
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RATE_DIV = DEFAULT_RATE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned DIV_W = div_width(RATE_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(RATE_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tc_c = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Execution sequencer for the single-clock MIPS core: single-step, free-run and PC breakpoint,
// issuing one registered CPU_CE pulse per committed instruction.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RATE_DIV = DEFAULT_RATE_DIV,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             STEP,
  input  logic             RUN,
  input  logic             BRK_EN,
  input  logic [31:0]      BRK_PC,
  input  logic [31:0]      PC,
  output logic             CPU_CE,
  output logic             RUNNING,
  output logic             BRK_HIT,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STEP_CNT
);

  run_state_e state_q, state_d;
  logic       skip_q, skip_d;
  logic       ce_d;
  logic       div_en, div_clr;
  logic       tick;
  logic       brk_match;

  // The RUN pulse cycle is count 0 of the first period; the divider idles at 0 outside RUN.
  assign div_en  = RUN ? (state_q != S_RUN) : (state_q == S_RUN);
  assign div_clr = !div_en;

  mips_tick_gen #(
    .RATE_DIV (RATE_DIV)
  ) u_tick_gen (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (div_clr),
    .en    (div_en),
    .tc_c  (tick)
  );

  // skip lets the first decision after a resume step off the breakpoint address
  assign brk_match = BRK_EN && (PC == BRK_PC) && !skip_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ce_d    = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (RUN) begin
          state_d = S_RUN;
          skip_d  = 1'b0;
        end else if (STEP) begin
          ce_d = 1'b1;
        end
      end
      S_RUN: begin
        if (RUN) begin
          state_d = S_HALT;
        end else if (tick) begin
          if (brk_match) begin
            state_d = S_BRK;
          end else begin
            ce_d   = 1'b1;
            skip_d = 1'b0;
          end
        end
      end
      S_BRK: begin
        if (RUN) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end else if (STEP) begin
          ce_d    = 1'b1;
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_HALT;
      skip_q   <= 1'b0;
      CPU_CE   <= 1'b0;
      RUNNING  <= 1'b0;
      BRK_HIT  <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      CPU_CE  <= ce_d;
      RUNNING <= (state_d == S_RUN);
      BRK_HIT <= (state_d == S_BRK);
      if (ce_d) begin
        STEP_CNT <= STEP_CNT + CNT_W'(1);
      end
    end
  end

  assign STATE = state_q;

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Execution sequencer for the single-clock MIPS core on the DE10-Lite board.
- The core runs on the 50 MHz board clock CLK; this block issues a one-cycle clock-enable pulse (CPU_CE) per instruction.
- Modes: single-step from a debounced key, free-run at a divided rate, and halt on a PC breakpoint.
- Sits between the debounced button outputs and the core; status outputs drive LEDR.

Parameters:
RATE_DIV, 25000000, CLK cycles per instruction in RUN (2 Hz at 50 MHz); legal minimum 1
CNT_W, 16, width of the executed-instruction counter

Ports:
CLK      input   1      board clock, 50 MHz; all logic on rising edge
nRST     input   1      synchronous, active-low reset
STEP     input   1      single-cycle pulse (debounced key): execute one instruction
RUN      input   1      single-cycle pulse: toggle run/stop, or resume from breakpoint
BRK_EN   input   1      level: breakpoint compare enabled
BRK_PC   input   32     breakpoint address
PC       input   32     current PC of the core
CPU_CE   output  1      registered one-cycle enable; core commits one instruction per pulse
RUNNING  output  1      1 while in RUN
BRK_HIT  output  1      1 while in BRK
STATE    output  2      00 HALT, 01 RUN, 10 BRK
STEP_CNT output  CNT_W  number of CPU_CE pulses issued, wraps modulo 2^CNT_W

Behaviour:
- Reset: nRST low at a rising edge sets STATE=HALT, CPU_CE=0, STEP_CNT=0, divider=0, skip flag=0, RUNNING=0, BRK_HIT=0.
- Reset overrides everything, including a pulse due mid-operation: CPU_CE is 0 in the cycle after reset.
- All outputs are registered.
- CPU_CE is never high for two consecutive cycles, except in RUN with RATE_DIV=1.
- HALT:
  - STEP at cycle n -> CPU_CE=1 at n+1 for exactly one cycle; stays HALT.
  - RUN -> RUN; divider cleared; skip flag cleared.
- RUN:
  - Divider counts 0..RATE_DIV-1 and wraps to 0.
  - At terminal count (divider == RATE_DIV-1) the issue decision is made:
    - If BRK_EN=1, PC==BRK_PC (full 32 bits) and skip=0 -> go to BRK; no CPU_CE.
    - Otherwise CPU_CE=1 next cycle and skip is cleared.
  - RUN pulse -> HALT, divider cleared; no CPU_CE is issued from the decision cycle, even if it coincides with terminal count.
  - STEP is ignored.
  - RATE_DIV=1: a decision every cycle; CPU_CE continuous, first pulse one cycle after entry.
- BRK:
  - STEP -> one CPU_CE at next cycle; state goes to HALT.
  - RUN -> RUN with divider cleared and skip=1, so the first issue decision bypasses the compare and the core can leave the breakpoint address.
  - BRK_EN deasserted while in BRK: state is held until STEP or RUN.
- Simultaneous STEP and RUN in the same cycle: RUN takes precedence; STEP is dropped.
- STEP_CNT increments in the same cycle CPU_CE is high; wraps from 2^CNT_W-1 to 0.
- PC is sampled combinationally at the decision cycle. PC changes only after a CPU_CE, so the compare always sees the next instruction to execute.
- Divider width: clog2(RATE_DIV), minimum 1 bit.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state encoding constants ST_HALT=2'b00, ST_RUN=2'b01, ST_BRK=2'b10
  - default rate constant for the 50 MHz clock
- One sub-module, mips_tick_gen: parameterized RATE_DIV divider with synchronous clear and a terminal-count strobe; instantiated once.
- The FSM, breakpoint compare and step counter stay in mips_run_ctrl.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with STEP/RUN pulsing -> STATE=00, CPU_CE=0, STEP_CNT=0 throughout and one cycle after release.
- Single-step: in HALT, STEP pulses at cycles 10 and 20 -> CPU_CE high only at 11 and 21, STEP_CNT=2, STATE stays 00.
- Free-run: RATE_DIV=4, RUN pulse at cycle 5 -> CPU_CE at cycles 9, 13, 17, …; RUN pulse at cycle 16 -> no pulse at 17, STATE=00, STEP_CNT=2.
- Breakpoint: RATE_DIV=4, BRK_EN=1, BRK_PC=0x0000000C, PC model advancing +4 per CPU_CE from 0 -> three pulses (PC 0, 4, 8), then STATE=10, BRK_HIT=1, no CPU_CE while PC=0x0C.
- Resume and step from BRK:
  - RUN pulse -> next issue passes the compare, PC=0x10, STATE=01.
  - From a separate BRK, STEP -> one CPU_CE, STATE=00.
- Simultaneous STEP+RUN in HALT -> STATE=01, no CPU_CE next cycle. Also CNT_W=4 with 17 steps -> STEP_CNT=1 (wrap).
